// File: rtl/in_sram_pp.sv
// in_sram_pp: two-bank ping-pong input buffer. The loader fills one bank
// column by column while the MAC array drains the other in index order.
// Each side has a valid/ready handshake.
module in_sram_pp #(
  parameter  int DATA_W = 16,
  parameter  int ROWS   = 10,
  parameter  int DEPTH  = 784,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ROWS*DATA_W-1:0] wr_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [ROWS*DATA_W-1:0] rd_data,
  output logic [AW-1:0]          rd_idx,
  output logic                   rd_last,
  output logic [1:0]             banks_full
);

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  // Column storage, one word per pixel index holding all rows.
  logic [ROWS*DATA_W-1:0] mem [2][DEPTH];

  bank_state_e state_q [2];
  bank_state_e state_d [2];
  logic                   wbank_q, wbank_d;
  logic                   rbank_q, rbank_d;
  logic [AW-1:0]          wptr_q, wptr_d;
  logic [AW-1:0]          rptr_q, rptr_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [ROWS*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [AW-1:0]          rd_idx_q, rd_idx_d;
  logic                   rd_last_q, rd_last_d;

  logic mem_we;
  logic wr_fire;
  logic rd_load;
  logic rbank_readable;

  // The write bank only accepts while it is not yet handed to the reader.
  assign wr_ready = (state_q[wbank_q] == BANK_EMPTY) || (state_q[wbank_q] == BANK_FILLING);
  assign wr_fire  = wr_valid && wr_ready;

  assign rbank_readable = (state_q[rbank_q] == BANK_FULL) || (state_q[rbank_q] == BANK_DRAINING);
  assign rd_load        = (!rd_valid_q || rd_ready) && rbank_readable;

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_idx   = rd_idx_q;
  assign rd_last  = rd_last_q;

  // Count banks currently owned by the read side.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    banks_full = 2'd0;
    for (int b = 0; b < 2; b++) begin
      if ((state_q[b] == BANK_FULL) || (state_q[b] == BANK_DRAINING)) begin
        banks_full = banks_full + 2'd1;
      end
    end
  end

  // Next-state for bank states, pointers and the output register.
  always_comb begin
    state_d    = state_q;
    wbank_d    = wbank_q;
    rbank_d    = rbank_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    rd_idx_d   = rd_idx_q;
    rd_last_d  = rd_last_q;
    mem_we     = 1'b0;

    if (flush) begin
      // Flush wins over any same-cycle beat; stored pixels are left in place.
      state_d[0] = BANK_EMPTY;
      state_d[1] = BANK_EMPTY;
      wbank_d    = 1'b0;
      rbank_d    = 1'b0;
      wptr_d     = '0;
      rptr_d     = '0;
      rd_valid_d = 1'b0;
    end else begin
      if (wr_fire) begin
        mem_we = 1'b1;
        if (wptr_q == LAST_IDX) begin
          state_d[wbank_q] = BANK_FULL;
          wptr_d           = '0;
          wbank_d          = ~wbank_q;
        end else begin
          state_d[wbank_q] = BANK_FILLING;
          wptr_d           = wptr_q + AW'(1);
        end
      end

      // The read bank is FULL/DRAINING and the write bank EMPTY/FILLING,
      // so the two updates above and below never touch the same bank.
      if (rd_load) begin
        rd_data_d  = mem[rbank_q][rptr_q];
        rd_idx_d   = rptr_q;
        rd_last_d  = (rptr_q == LAST_IDX);
        rd_valid_d = 1'b1;
        if (rptr_q == LAST_IDX) begin
          state_d[rbank_q] = BANK_EMPTY;
          rptr_d           = '0;
          rbank_d          = ~rbank_q;
        end else begin
          state_d[rbank_q] = BANK_DRAINING;
          rptr_d           = rptr_q + AW'(1);
        end
      end else if (rd_valid_q && rd_ready) begin
        rd_valid_d = 1'b0;
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      state_q    <= '{BANK_EMPTY, BANK_EMPTY};
      wbank_q    <= 1'b0;
      rbank_q    <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_idx_q   <= '0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wbank_q    <= wbank_d;
      rbank_q    <= rbank_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_idx_q   <= rd_idx_d;
      rd_last_q  <= rd_last_d;
    end
  end

  // Column write into the current write bank.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; bank state alone decides what is valid, so it maps onto plain RAM.
    if (mem_we) begin
      mem[wbank_q][wptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_in_sram_pp.sv
// tb_in_sram_pp: directed bench for in_sram_pp. A small instance
// (DEPTH=4, ROWS=2) covers handshake, ping-pong, backpressure and flush.
// A default-size instance covers async reset and a full 784-column round trip.
module tb_in_sram_pp;

  localparam int SW  = 16;
  localparam int SR  = 2;
  localparam int SD  = 4;
  localparam int SAW = 2;
  localparam int BR  = 10;
  localparam int BW  = 16;
  localparam int BD  = 784;
  localparam int BAW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Small instance signals
  logic               s_flush, s_wr_valid, s_wr_ready, s_rd_valid, s_rd_ready, s_rd_last;
  logic [SR*SW-1:0]   s_wr_data, s_rd_data;
  logic [SAW-1:0]     s_rd_idx;
  logic [1:0]         s_banks_full;

  // Default-size instance signals
  logic               b_flush, b_wr_valid, b_wr_ready, b_rd_valid, b_rd_ready, b_rd_last;
  logic [BR*BW-1:0]   b_wr_data, b_rd_data;
  logic [BAW-1:0]     b_rd_idx;
  logic [1:0]         b_banks_full;

  in_sram_pp #(.DATA_W(SW), .ROWS(SR), .DEPTH(SD)) u_small (
    .clk        (clk),
    .rst        (rst),
    .flush      (s_flush),
    .wr_valid   (s_wr_valid),
    .wr_ready   (s_wr_ready),
    .wr_data    (s_wr_data),
    .rd_valid   (s_rd_valid),
    .rd_ready   (s_rd_ready),
    .rd_data    (s_rd_data),
    .rd_idx     (s_rd_idx),
    .rd_last    (s_rd_last),
    .banks_full (s_banks_full)
  );

  in_sram_pp u_big (
    .clk        (clk),
    .rst        (rst),
    .flush      (b_flush),
    .wr_valid   (b_wr_valid),
    .wr_ready   (b_wr_ready),
    .wr_data    (b_wr_data),
    .rd_valid   (b_rd_valid),
    .rd_ready   (b_rd_ready),
    .rd_data    (b_rd_data),
    .rd_idx     (b_rd_idx),
    .rd_last    (b_rd_last),
    .banks_full (b_banks_full)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [SR*SW-1:0] data;
    logic [SAW-1:0]   idx;
    logic             last;
  } beat_t;

  beat_t exp_q[$];
  int    wr_seq = 0;
  int    wr_cnt = 0;
  int    rd_cnt = 0;

  // Small-instance column n: row0 = n, row1 = 0x0100 + n.
  function automatic logic [SR*SW-1:0] scol(input int n);
    return {16'(16'h0100 + n), 16'(n)};
  endfunction

  // Default-instance column n with a per-fill salt.
  function automatic logic [BR*BW-1:0] bcol(input int n, input int salt);
    logic [BR*BW-1:0] v;
    v = '0;
    for (int r = 0; r < BR; r++) v[r*BW +: BW] = 16'(n * 37 + r * 4099 + salt * 12345);
    return v;
  endfunction

  // One clock of the small instance, called at a falling edge with inputs set.
  // Records handshakes seen by the coming rising edge and checks stall stability.
  task automatic step();
    logic             hold;
    logic [SR*SW-1:0] hd;
    logic [SAW-1:0]   hi;
    beat_t            e;
    hold = s_rd_valid && !s_rd_ready && !s_flush;
    hd   = s_rd_data;
    hi   = s_rd_idx;
    if (s_flush) begin
      exp_q.delete();
      wr_seq = 0;
    end else begin
      if (s_rd_valid && s_rd_ready) begin
        rd_cnt++;
        check("sb_avail", 160'(exp_q.size() > 0), 160'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sb_data", 160'(s_rd_data), 160'(e.data));
          check("sb_idx",  160'(s_rd_idx),  160'(e.idx));
          check("sb_last", 160'(s_rd_last), 160'(e.last));
        end
      end
      if (s_wr_valid && s_wr_ready) begin
        e.data = s_wr_data;
        e.idx  = SAW'(wr_seq % SD);
        e.last = ((wr_seq % SD) == SD - 1);
        exp_q.push_back(e);
        wr_seq++;
        wr_cnt++;
      end
    end
    @(negedge clk);
    if (hold) begin
      check("stall_valid", 160'(s_rd_valid), 160'(1));
      check("stall_data",  160'(s_rd_data),  160'(hd));
      check("stall_idx",   160'(s_rd_idx),   160'(hi));
    end
  endtask

  task automatic do_flush();
    s_flush    = 1'b1;
    s_wr_valid = 1'b0;
    s_rd_ready = 1'b0;
    step();
    s_flush = 1'b0;
    wr_cnt  = 0;
    rd_cnt  = 0;
  endtask

  task automatic write_small(input int base, input int count);
    for (int i = 0; i < count; i++) begin
      s_wr_valid = 1'b1;
      s_wr_data  = scol(base + i);
      step();
    end
    s_wr_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bw;
    int br;

    rst        = 1'b1;
    s_flush    = 1'b0; s_wr_valid = 1'b0; s_rd_ready = 1'b0; s_wr_data = '0;
    b_flush    = 1'b0; b_wr_valid = 1'b0; b_rd_ready = 1'b0; b_wr_data = '0;
    @(negedge clk);
    @(negedge clk);

    // Reset values
    check("rst_wr_ready", 160'(s_wr_ready),   160'(1));
    check("rst_rd_valid", 160'(s_rd_valid),   160'(0));
    check("rst_rd_data",  160'(s_rd_data),    160'(0));
    check("rst_rd_idx",   160'(s_rd_idx),     160'(0));
    check("rst_rd_last",  160'(s_rd_last),    160'(0));
    check("rst_bf",       160'(s_banks_full), 160'(0));
    rst = 1'b0;
    @(negedge clk);

    // Fill then drain one bank
    do_flush();
    s_rd_ready = 1'b1;
    write_small(1, 4);
    check("fd_rv_t1", 160'(s_rd_valid),   160'(0));
    check("fd_bf_t1", 160'(s_banks_full), 160'(1));
    step();
    check("fd_rv_t2",  160'(s_rd_valid), 160'(1));
    check("fd_idx0",   160'(s_rd_idx),   160'(0));
    check("fd_data0",  160'(s_rd_data),  160'(32'h0101_0001));
    check("fd_last0",  160'(s_rd_last),  160'(0));
    for (int i = 0; i < 4; i++) begin
      if (s_rd_valid) check("fd_last", 160'(s_rd_last), 160'(s_rd_idx == 2'd3));
      step();
    end
    check("fd_reads",    160'(rd_cnt),       160'(4));
    check("fd_rv_done",  160'(s_rd_valid),   160'(0));
    check("fd_bf_done",  160'(s_banks_full), 160'(0));

    // Ping-pong: three banks written back to back
    do_flush();
    s_rd_ready = 1'b1;
    for (int c = 0; c < 40 && rd_cnt < 12; c++) begin
      if (rd_cnt >= 1 && rd_cnt < 12) check("pp_nogap", 160'(s_rd_valid), 160'(1));
      if (wr_cnt < 12) check("pp_wr_ready", 160'(s_wr_ready), 160'(1));
      check("pp_bf_le2", 160'(s_banks_full != 2'd3), 160'(1));
      s_wr_valid = (wr_cnt < 12);
      s_wr_data  = scol(16 + wr_cnt);
      step();
    end
    s_wr_valid = 1'b0;
    check("pp_reads",  160'(rd_cnt),        160'(12));
    check("pp_sb_end", 160'(exp_q.size()),  160'(0));

    // Backpressure with both banks held by the reader
    do_flush();
    write_small(32, 8);
    check("bp_wr_ready0", 160'(s_wr_ready),   160'(0));
    check("bp_bf2",       160'(s_banks_full), 160'(2));
    check("bp_rv",        160'(s_rd_valid),   160'(1));
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_data", 160'(s_rd_data),  160'(32'h0120_0020));
      check("bp_hold_idx",  160'(s_rd_idx),   160'(0));
      check("bp_hold_wr",   160'(s_wr_ready), 160'(0));
      step();
    end
    s_rd_ready = 1'b1;
    step();
    check("bp_wr_q1", 160'(s_wr_ready), 160'(0));
    step();
    check("bp_wr_q2", 160'(s_wr_ready), 160'(0));
    step();
    check("bp_wr_rise", 160'(s_wr_ready), 160'(1));
    for (int c = 0; c < 20 && rd_cnt < 8; c++) step();
    check("bp_reads", 160'(rd_cnt), 160'(8));

    // Toggled rd_ready
    do_flush();
    for (int c = 0; c < 60 && rd_cnt < 8; c++) begin
      s_rd_ready = (c % 2 == 0);
      s_wr_valid = (wr_cnt < 8);
      s_wr_data  = scol(48 + wr_cnt);
      step();
    end
    s_wr_valid = 1'b0;
    check("tog_reads",  160'(rd_cnt),       160'(8));
    check("tog_sb_end", 160'(exp_q.size()), 160'(0));

    // Flush mid-fill, with a beat offered in the flush cycle
    do_flush();
    s_rd_ready = 1'b1;
    write_small(64, 2);
    s_wr_valid = 1'b1;
    s_wr_data  = scol(66);
    s_flush    = 1'b1;
    step();
    s_flush    = 1'b0;
    s_wr_valid = 1'b0;
    check("ff_rv", 160'(s_rd_valid),   160'(0));
    check("ff_bf", 160'(s_banks_full), 160'(0));
    check("ff_wr", 160'(s_wr_ready),   160'(1));
    rd_cnt = 0;
    write_small(80, 4);
    for (int c = 0; c < 20 && rd_cnt < 4; c++) step();
    check("ff_reads",  160'(rd_cnt),       160'(4));
    check("ff_sb_end", 160'(exp_q.size()), 160'(0));

    // Flush mid-drain with idx 1 held
    do_flush();
    write_small(96, 4);
    for (int c = 0; c < 10 && !s_rd_valid; c++) step();
    check("fm_rv", 160'(s_rd_valid), 160'(1));
    s_rd_ready = 1'b1;
    step();
    s_rd_ready = 1'b0;
    check("fm_idx1", 160'(s_rd_idx), 160'(1));
    step();
    check("fm_idx1_hold", 160'(s_rd_idx), 160'(1));
    s_flush = 1'b1;
    step();
    s_flush = 1'b0;
    check("fm_rv0", 160'(s_rd_valid),   160'(0));
    check("fm_bf0", 160'(s_banks_full), 160'(0));
    check("fm_wr1", 160'(s_wr_ready),   160'(1));
    rd_cnt = 0;
    s_rd_ready = 1'b1;
    write_small(112, 4);
    for (int c = 0; c < 20 && rd_cnt < 4; c++) step();
    check("fm_reads",  160'(rd_cnt),       160'(4));
    check("fm_sb_end", 160'(exp_q.size()), 160'(0));

    // Default size: stream, then async reset between edges
    b_rd_ready = 1'b1;
    bw = 0;
    br = 0;
    for (int c = 0; c < 2000 && br < 5; c++) begin
      if (b_rd_valid) br++;
      b_wr_valid = (bw < BD + 6);
      b_wr_data  = bcol(bw, 0);
      if (b_wr_valid && b_wr_ready) bw++;
      @(negedge clk);
    end
    check("ar_streaming", 160'(b_rd_valid), 160'(1));
    #2;
    rst = 1'b1;
    #1;
    check("ar_wr_ready", 160'(b_wr_ready),   160'(1));
    check("ar_rd_valid", 160'(b_rd_valid),   160'(0));
    check("ar_rd_data",  160'(b_rd_data),    160'(0));
    check("ar_rd_idx",   160'(b_rd_idx),     160'(0));
    check("ar_rd_last",  160'(b_rd_last),    160'(0));
    check("ar_bf",       160'(b_banks_full), 160'(0));
    @(negedge clk);
    rst = 1'b0;

    // Full fill after reset reads back bit-exact from index 0
    bw = 0;
    br = 0;
    for (int c = 0; c < 3000 && br < BD; c++) begin
      if (b_rd_valid) begin
        check("big_data", 160'(b_rd_data), 160'(bcol(br, 1)));
        check("big_idx",  160'(b_rd_idx),  160'(br));
        check("big_last", 160'(b_rd_last), 160'(br == BD - 1));
        br++;
      end
      b_wr_valid = (bw < BD);
      b_wr_data  = bcol(bw, 1);
      if (b_wr_valid && b_wr_ready) bw++;
      @(negedge clk);
    end
    b_wr_valid = 1'b0;
    check("big_reads", 160'(br), 160'(BD));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
